fifo_drain_ctrl: RTL and testbench

// Read-side master for the shared fifo: issues rd_en, captures rd_data on rd_vld
// (1-cycle read latency) and re-presents words on a valid/ready stream downstream.

---
 rtl/fifo_drain_pkg.sv | 10 +
 rtl/fifo_drain_skid.sv | 44 ++++
 rtl/fifo_drain_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_drain_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and sizing for the fifo drain controller and its skid buffer.
package fifo_drain_pkg;

   typedef enum logic [1:0] {IDLE, RUN, GAP, FLUSH} drain_state_t;

   localparam int SKID_DEPTH = 2;
   // Wide enough to hold 0..SKID_DEPTH (occupancy / credits in use).
   localparam int CRED_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer catching fifo read data; head is presented downstream.
module fifo_drain_skid
   import fifo_drain_pkg::*;
#(
   parameter int DATA_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [CRED_W-1:0] occ,
   output logic [DATA_W-1:0] head
);

   logic [SKID_DEPTH-1:0][DATA_W-1:0] mem;
   logic                              wr_ptr;
   logic                              rd_ptr;
   logic                              do_push;
   logic                              do_pop;

   // A push into a full buffer is only legal when the head leaves the same cycle.
   assign do_pop  = pop && (occ != '0);
   assign do_push = push && ((occ < CRED_W'(SKID_DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         occ <= occ + CRED_W'(do_push) - CRED_W'(do_pop);
      end
   end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side fifo master: credit-limited pops, burst/gap pacing, valid/ready output.
module fifo_drain_ctrl
   import fifo_drain_pkg::*;
#(
   parameter int DATA_W     = 3,
   parameter int BURST_LEN  = 50,
   parameter int GAP_CYCLES = 10,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   output logic              rd_en,
   input  logic              rd_vld,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic [CNT_W-1:0]  pop_cnt,
   output logic              proto_err
);

   localparam int BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int UW      = CRED_W + 1;
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'((BURST_LEN > 0) ? BURST_LEN - 1 : 0);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   drain_state_t       state;
   logic               infl;
   logic               rst_d;
   logic               out_xfer;
   logic               skid_push;
   logic [CRED_W-1:0]  occ;
   logic [UW-1:0]      credits_used;
   logic [BURST_W-1:0] burst_cnt;
   logic [GAP_W-1:0]   gap_cnt;

   // A word leaving downstream this cycle frees its credit immediately, which
   // is what allows one pop per cycle at full throughput.
   assign out_xfer     = out_vld && out_rdy;
   assign credits_used = UW'(infl) + UW'(occ) - UW'(out_xfer);
   assign rd_en        = (state == RUN) && !fifo_empty && (credits_used < UW'(SKID_DEPTH));
   assign skid_push    = rd_vld && infl;
   assign out_vld      = (occ != '0);
   assign busy         = (state != IDLE) || infl || out_vld;

   fifo_drain_skid #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (skid_push),
      .push_data (rd_data),
      .pop       (out_xfer),
      .occ       (occ),
      .head      (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         infl      <= 1'b0;
         rst_d     <= 1'b1;
         burst_cnt <= '0;
         gap_cnt   <= '0;
         pop_cnt   <= '0;
         proto_err <= 1'b0;
      end else begin
         rst_d <= 1'b0;
         infl  <= rd_en;
         if (rd_en)
            pop_cnt <= pop_cnt + CNT_W'(1);
         // A read issued just before reset may still return; that word is not an error.
         if (rd_vld && !infl && !rst_d)
            proto_err <= 1'b1;
         unique case (state)
            IDLE: begin
               burst_cnt <= '0;
               gap_cnt   <= '0;
               if (enable)
                  state <= RUN;
            end
            RUN: begin
               if (rd_en) begin
                  if ((BURST_LEN != 0) && (burst_cnt == BURST_LAST)) begin
                     burst_cnt <= '0;
                     gap_cnt   <= '0;
                     state     <= GAP;
                  end else begin
                     burst_cnt <= burst_cnt + BURST_W'(1);
                  end
               end
               if (!enable)
                  state <= FLUSH;
            end
            GAP: begin
               if (!enable)
                  state <= FLUSH;
               else if (gap_cnt == GAP_LAST)
                  state <= RUN;
               else
                  gap_cnt <= gap_cnt + GAP_W'(1);
            end
            FLUSH: begin
               if (!infl && (occ == '0))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench: fifo stand-in, queue-based reference model checked every cycle.
module tb_fifo_drain_ctrl;

   localparam int DATA_W     = 3;
   localparam int BURST_LEN  = 50;
   localparam int GAP_CYCLES = 10;
   localparam int CNT_W      = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              enable = 1'b0;
   logic              fifo_empty = 1'b1;
   logic              rd_vld = 1'b0;
   logic [DATA_W-1:0] rd_data = '0;
   logic              out_rdy = 1'b0;
   logic              rd_en;
   logic              out_vld;
   logic [DATA_W-1:0] out_data;
   logic              busy;
   logic [CNT_W-1:0]  pop_cnt;
   logic              proto_err;

   always #5 clk = ~clk;

   fifo_drain_ctrl #(
      .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .rd_en(rd_en),
      .rd_vld(rd_vld), .rd_data(rd_data), .out_vld(out_vld), .out_rdy(out_rdy),
      .out_data(out_data), .busy(busy), .pop_cnt(pop_cnt), .proto_err(proto_err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // fifo stand-in
   int fq[$];
   bit pend = 0;
   int pend_data = 0;
   bit force_vld = 0;
   int force_data = 0;

   // reference model
   localparam int M_IDLE = 0, M_RUN = 1, M_GAP = 2, M_FLUSH = 3;
   int m_st = M_IDLE;
   int m_burst = 0, m_gap = 0, m_pop = 0;
   bit m_infl = 0, m_err = 0, m_rst_prev = 0;
   int m_skid[$];
   bit chk_on = 0;

   // observations
   int got[$];
   int rd_en_cycles[$];
   int first_vld = -1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      bit exp_rd_en;
      bit flush_done;
      int used;
      fifo_empty = (fq.size() == 0);
      rd_vld     = pend | force_vld;
      rd_data    = DATA_W'(pend ? pend_data : force_data);
      #1;
      used = int'(m_infl) + m_skid.size() - ((m_skid.size() > 0 && out_rdy) ? 1 : 0);
      exp_rd_en = (m_st == M_RUN) && (fq.size() != 0) && (used < 2);
      if (chk_on) begin
         check("rd_en", rd_en, exp_rd_en);
         check("out_vld", out_vld, m_skid.size() > 0);
         if (m_skid.size() > 0) check("out_data", out_data, m_skid[0]);
         check("busy", busy, (m_st != M_IDLE) || m_infl || (m_skid.size() > 0));
         check("pop_cnt", pop_cnt, m_pop);
         check("proto_err", proto_err, m_err);
      end
      if (out_vld && out_rdy) got.push_back(int'(out_data));
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (rd_en) rd_en_cycles.push_back(cyc);
      // model advance across the coming clock edge
      if (rst) begin
         m_st = M_IDLE; m_infl = 0; m_skid.delete(); m_burst = 0; m_gap = 0;
         m_pop = 0; m_err = 0; m_rst_prev = 1;
      end else begin
         flush_done = !m_infl && (m_skid.size() == 0);
         if (m_skid.size() > 0 && out_rdy) m_skid.delete(0);
         if (rd_vld) begin
            if (m_infl) m_skid.push_back(int'(rd_data));
            else if (!m_rst_prev) m_err = 1;
         end
         m_rst_prev = 0;
         case (m_st)
            M_IDLE: begin
               m_burst = 0; m_gap = 0;
               if (enable) m_st = M_RUN;
            end
            M_RUN: begin
               if (exp_rd_en) begin
                  if (BURST_LEN != 0 && m_burst + 1 == BURST_LEN) begin
                     m_st = M_GAP; m_burst = 0; m_gap = 0;
                  end else m_burst++;
               end
               if (!enable) m_st = M_FLUSH;
            end
            M_GAP: begin
               if (!enable) m_st = M_FLUSH;
               else if (m_gap + 1 >= GAP_CYCLES) m_st = M_RUN;
               else m_gap++;
            end
            default: if (flush_done) m_st = M_IDLE;
         endcase
         m_infl = exp_rd_en;
         if (exp_rd_en) m_pop = (m_pop + 1) % (1 << CNT_W);
      end
      pend = rd_en;
      if (rd_en) pend_data = (fq.size() > 0) ? fq.pop_front() : 0;
      force_vld = 0;
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset(input string tag);
      rst = 1; enable = 0; out_rdy = 0;
      step();
      rst = 0; chk_on = 1;
      check({tag, "_rst_out_vld"}, out_vld, 0);
      check({tag, "_rst_out_data"}, out_data, 0);
      check({tag, "_rst_rd_en"}, rd_en, 0);
      check({tag, "_rst_busy"}, busy, 0);
      check({tag, "_rst_pop_cnt"}, pop_cnt, 0);
      check({tag, "_rst_proto_err"}, proto_err, 0);
      got.delete(); rd_en_cycles.delete(); first_vld = -1;
   endtask

   task automatic drain_to_idle(input string tag);
      enable = 0; out_rdy = 1;
      for (int k = 0; k < 30 && busy; k++) step();
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      int r0;
      @(negedge clk);

      // 1: four words, straight through
      fq.delete();
      do_reset("s1");
      for (int i = 0; i < 4; i++) fq.push_back(i);
      enable = 1; out_rdy = 1;
      for (int i = 0; i < 12; i++) step();
      r0 = (rd_en_cycles.size() > 0) ? rd_en_cycles[0] : -100;
      check("s1_latency", first_vld - r0, 2);
      check("s1_pop_cnt_lit", pop_cnt, 4);
      check("s1_count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) check("s1_word", got[i], i);
      drain_to_idle("s1");

      // 2: 100 words with burst/gap pacing
      fq.delete();
      do_reset("s2");
      for (int i = 0; i < 100; i++) fq.push_back(i % 8);
      enable = 1; out_rdy = 1;
      for (int k = 0; k < 400 && got.size() < 100; k++) step();
      check("s2_count", got.size(), 100);
      for (int i = 0; i < 100 && i < got.size(); i++) check("s2_word", got[i], i % 8);
      check("s2_pops", rd_en_cycles.size(), 100);
      if (rd_en_cycles.size() >= 51) begin
         check("s2_burst_span", rd_en_cycles[49] - rd_en_cycles[0], 49);
         check("s2_gap", rd_en_cycles[50] - rd_en_cycles[49], 11);
      end else check("s2_enough_pops", rd_en_cycles.size(), 51);
      drain_to_idle("s2");

      // 3: backpressure, then resume
      fq.delete();
      do_reset("s3");
      fq = '{3, 4, 5, 6, 7, 1};
      enable = 1; out_rdy = 0;
      for (int i = 0; i < 10; i++) step();
      check("s3_pulses", rd_en_cycles.size(), 2);
      check("s3_vld_held", out_vld, 1);
      check("s3_data_held", out_data, 3);
      out_rdy = 1;
      for (int k = 0; k < 40 && got.size() < 6; k++) step();
      check("s3_count", got.size(), 6);
      if (got.size() == 6) begin
         check("s3_w0", got[0], 3); check("s3_w2", got[2], 5); check("s3_w5", got[5], 1);
      end
      drain_to_idle("s3");

      // 4: enable drops with one word in flight and one buffered
      fq.delete();
      do_reset("s4");
      fq = '{6, 2, 5, 0};
      enable = 1; out_rdy = 0;
      for (int i = 0; i < 3; i++) step();
      enable = 0;
      for (int i = 0; i < 5; i++) step();
      out_rdy = 1;
      for (int k = 0; k < 20 && busy; k++) step();
      check("s4_no_new_rd", rd_en_cycles.size(), 2);
      check("s4_count", got.size(), 2);
      if (got.size() == 2) begin
         check("s4_w0", got[0], 6); check("s4_w1", got[1], 2);
      end
      check("s4_busy", busy, 0);

      // 5: spurious rd_vld is sticky; rd_vld right after reset is ignored
      fq.delete();
      do_reset("s5");
      step(); step();
      force_vld = 1; force_data = 5;
      step();
      check("s5_err_set", proto_err, 1);
      for (int i = 0; i < 3; i++) step();
      check("s5_err_sticky", proto_err, 1);
      do_reset("s5b");
      force_vld = 1; force_data = 2;
      step();
      check("s5_post_rst_ignored", proto_err, 0);
      check("s5_post_rst_dropped", out_vld, 0);
      step();

      // 6: reset while the skid is full
      fq.delete();
      do_reset("s6");
      fq = '{1, 2, 3, 4};
      enable = 1; out_rdy = 0;
      for (int i = 0; i < 6; i++) step();
      check("s6_full_vld", out_vld, 1);
      check("s6_full_pops", pop_cnt, 2);
      do_reset("s6b");
      for (int i = 0; i < 3; i++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
